// File: rtl/array_sweep.sv
// Streams len words out of BRAM port A, adds a constant to each and writes the
// results back through port B, accumulating the raw words read into sum.
// Read-to-write latency is two cycles: address out, data back, then the write.
module array_sweep #(
  parameter int unsigned DEPTH  = 160,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [9:0]        src_base,
  input  logic [9:0]        dst_base,
  input  logic [7:0]        len,
  input  logic [DATA_W-1:0] addend,
  output logic              wea,
  output logic [9:0]        addra,
  output logic [DATA_W-1:0] dia,
  input  logic [DATA_W-1:0] doa,
  output logic              web,
  output logic [9:0]        addrb,
  output logic [DATA_W-1:0] dib,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [23:0]       sum
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;
  logic [9:0]        src_q, src_d, dst_q, dst_d;
  logic [7:0]        len_q, len_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] add_q, add_d;
  logic              rd_v_q, rd_v_d;   // a read address is on addra this cycle
  logic              wr_v_q, wr_v_d;   // doa carries data for a pending write
  logic [9:0]        wr_addr_q, wr_addr_d;
  logic [9:0]        addra_q, addra_d, addrb_q, addrb_d;
  logic [DATA_W-1:0] dib_q, dib_d;
  logic              web_q, web_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [23:0]       sum_q, sum_d;

  logic [10:0] src_end, dst_end;
  logic        params_ok;

  // Reject empty, out-of-range, and overlaps where a write would land ahead of its read.
  always_comb begin
    src_end   = {1'b0, src_base} + {3'b000, len};
    dst_end   = {1'b0, dst_base} + {3'b000, len};
    params_ok = (len != 8'd0) && (src_end <= 11'(DEPTH)) && (dst_end <= 11'(DEPTH)) &&
                !((src_base < dst_base) && ({1'b0, dst_base} < src_end));
  end

  // Next-state, read issue and write pipeline.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    add_d     = add_q;
    cnt_d     = cnt_q;
    rd_v_d    = 1'b0;
    wr_v_d    = rd_v_q;
    wr_addr_d = dst_q + (addra_q - src_q);
    addra_d   = addra_q;
    addrb_d   = addrb_q;
    dib_d     = dib_q;
    web_d     = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    sum_d     = sum_q;

    if (wr_v_q) begin
      web_d   = 1'b1;
      addrb_d = wr_addr_q;
      dib_d   = doa + add_q;
      sum_d   = sum_q + 24'(doa);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (params_ok) begin
            src_d   = src_base;
            dst_d   = dst_base;
            len_d   = len;
            add_d   = addend;
            cnt_d   = 8'd1;
            addra_d = src_base;
            rd_v_d  = 1'b1;
            busy_d  = 1'b1;
            sum_d   = '0;
            state_d = StRun;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (cnt_q == len_q) begin
          state_d = StDrain;
        end else begin
          addra_d = src_q + 10'(cnt_q);
          cnt_d   = cnt_q + 8'd1;
          rd_v_d  = 1'b1;
        end
      end
      StDrain: begin
        if (!rd_v_q && !wr_v_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset discards any in-flight writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      add_q     <= '0;
      cnt_q     <= '0;
      rd_v_q    <= 1'b0;
      wr_v_q    <= 1'b0;
      wr_addr_q <= '0;
      addra_q   <= '0;
      addrb_q   <= '0;
      dib_q     <= '0;
      web_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      add_q     <= add_d;
      cnt_q     <= cnt_d;
      rd_v_q    <= rd_v_d;
      wr_v_q    <= wr_v_d;
      wr_addr_q <= wr_addr_d;
      addra_q   <= addra_d;
      addrb_q   <= addrb_d;
      dib_q     <= dib_d;
      web_q     <= web_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      sum_q     <= sum_d;
    end
  end

  assign wea   = 1'b0;
  assign dia   = '0;
  assign addra = addra_q;
  assign addrb = addrb_q;
  assign dib   = dib_q;
  assign web   = web_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign sum   = sum_q;

endmodule

// File: doc/array_sweep.md
ARRAY_SWEEP -- requirements
Module: array_sweep

Interface
REQ-001 Parameter DEPTH, default 160, number of addressable BRAM words.
REQ-002 Parameter DATA_W, default 16, BRAM word width.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a sweep, sampled only in IDLE.
REQ-006 src_base  input  10  first BRAM address read.
REQ-007 dst_base  input  10  first BRAM address written.
REQ-008 len  input  8  number of words to process.
REQ-009 addend  input  16  constant added to each word read.
REQ-010 wea  output  1  BRAM port A write enable; held 0 (port A is read-only here).
REQ-011 addra  output  10  BRAM port A address.
REQ-012 dia  output  16  BRAM port A write data; held 0.
REQ-013 doa  input  16  BRAM port A read data, valid one cycle after addra.
REQ-014 web  output  1  BRAM port B write enable.
REQ-015 addrb  output  10  BRAM port B address.
REQ-016 dib  output  16  BRAM port B write data.
REQ-017 busy  output  1  high while a sweep is in progress.
REQ-018 done  output  1  one-cycle pulse at sweep completion.
REQ-019 err  output  1  one-cycle pulse when a start is rejected.
REQ-020 sum  output  24  sum of all words read in the last completed sweep.

Function
REQ-021 The FSM SHALL have states IDLE, RUN, DRAIN, DONE; all outputs registered.
REQ-022 IDLE + start=1 with valid parameters: latch src_base, dst_base, len, addend; clear sum accumulator; go to RUN; busy=1 next cycle.
REQ-023 Parameters invalid if len==0, src_base+len>DEPTH, dst_base+len>DEPTH, or src_base<dst_base<src_base+len; then err pulses one cycle, state stays IDLE, no BRAM access.
REQ-024 RUN: one read per cycle, addra=src_base+k for k=0..len-1 in consecutive cycles; RUN->DRAIN after the k=len-1 issue.
REQ-025 Pipeline: read issued in cycle n (doa valid cycle n+1) SHALL produce web=1, addrb=dst_base+k, dib=(doa+addend) mod 2^16 in cycle n+2.
REQ-026 Taking start sampled at edge 0: reads in cycles 1..len, writes in cycles 3..len+2, done=1 in cycle len+3, busy=1 in cycles 1..len+2.
REQ-027 DRAIN: no new reads; stays until the last write issued, then DONE.
REQ-028 DONE: done=1 for one cycle, busy=0, sum valid; next state IDLE.
REQ-029 sum SHALL be the unsigned sum of raw doa values (before addend); 24 bits never overflows for DEPTH<=160; sum holds until the next accepted start.
REQ-030 web SHALL be 0 in every cycle with no valid pipeline write; addrb/dib hold last values when web=0.
REQ-031 start while busy (RUN/DRAIN/DONE) is ignored, no err.
REQ-032 In-place sweep (src_base==dst_base) is valid; each address is read before it is written.
REQ-033 addra holds its last value when no read is issued.

Reset
REQ-034 reset=1 at any edge SHALL force state IDLE and busy, done, err, web, wea to 0; addra, addrb, dia, dib, sum to 0; all in-flight pipeline writes discarded.
REQ-035 After reset deasserts, the block SHALL accept start on the first following edge.

Verification
REQ-036 BRAM preloaded ram[i]=i; start with src_base=0, dst_base=40, len=4, addend=0x0100 -> writes ram[40..43]=0x0100..0x0103 in cycles 3..6, done in cycle 7, sum=6.
REQ-037 In-place: ram[10..12]=0xFFFF, src=dst=10, len=3, addend=2 -> ram[10..12]=0x0001, sum=0x02FFFD.
REQ-038 Rejects: len=0; src_base=150,len=20; src_base=5,dst_base=7,len=4 -> err pulse each, no web, busy stays 0.
REQ-039 Reset asserted in cycle 2 of a len=8 sweep -> no web from the next cycle on, all outputs 0, only already-issued writes landed.
REQ-040 start re-pulsed during RUN and in the DONE cycle -> ignored; exactly len writes, one done.
REQ-041 Full range: src_base=0, dst_base=80, len=80, ram[i]=0xFFFF -> 80 writes of addend-1, sum=80*65535=0x4FFFB0.
